// File: rtl/gru_hidden_seq.sv
// gru_hidden_seq
//   Sequencer for the GRU hidden-layer element datapath. Walks a vector of
//   vec_len elements, reads four operand buffers at the same address, feeds
//   the fixed-latency datapath one element per cycle, collects results in a
//   small FIFO and writes them back in address order under wr_ready
//   backpressure. Data (Q2.14) passes through bit-exact.
//
//   Handshakes:
//     rd_en   : single-cycle read strobe. Buffer read data must be settled by
//               the clock edge that closes the rd_en cycle; it is captured
//               into the dp_* registers there, so dp_en follows rd_en by
//               exactly one cycle.
//     dp_en / dp_result_valid : strobes only, no backpressure (datapath
//               cannot stall). An issue credit of FIFO_DEPTH guarantees every
//               issued element has a FIFO slot when its result arrives.
//     wr_en   : a write completes in every cycle where wr_en=1, and wr_en is
//               exactly (FIFO non-empty & wr_ready); wr_addr/wr_data are
//               valid whenever wr_en=1.
//
//   The reset input is named rst_n for legacy reasons but is ACTIVE-HIGH.

module gru_hidden_seq #(
    parameter int DATABIT    = 16,
    parameter int ADDRBIT    = 8,
    parameter int DP_LAT     = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDRBIT-1:0] vec_len,
    output logic               busy,
    output logic               done,
    output logic               ovf_err,
    output logic               rd_en,
    output logic [ADDRBIT-1:0] rd_addr,
    input  logic [DATABIT-1:0] mem_xt,
    input  logic [DATABIT-1:0] mem_htb,
    input  logic [DATABIT-1:0] mem_ht1,
    input  logic [DATABIT-1:0] mem_zt,
    output logic               dp_en,
    output logic [DATABIT-1:0] dp_xt,
    output logic [DATABIT-1:0] dp_htb,
    output logic [DATABIT-1:0] dp_ht1,
    output logic [DATABIT-1:0] dp_zt,
    input  logic               dp_result_valid,
    input  logic [DATABIT-1:0] dp_result,
    output logic               wr_en,
    output logic [ADDRBIT-1:0] wr_addr,
    output logic [DATABIT-1:0] wr_data,
    input  logic               wr_ready,
    output logic [1:0]         dbg_state
);

    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

    // Reject parameter sets the credit scheme cannot handle.
    generate
        if (DP_LAT < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $error("gru_hidden_seq: DP_LAT must be >= 1 and FIFO_DEPTH a power of 2 >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDRBIT-1:0] len_q, len_d;
    logic [ADDRBIT-1:0] issue_cnt_q, issue_cnt_d;
    logic [ADDRBIT-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNTW-1:0]    credit_q, credit_d;

    logic [PTRW-1:0]    fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [PTRW-1:0]    fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [CNTW-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [DATABIT-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATABIT-1:0] fifo_mem_d [FIFO_DEPTH];
    logic               ovf_q, ovf_d;

    logic               dp_en_q, dp_en_d;
    logic [DATABIT-1:0] dp_xt_q, dp_xt_d;
    logic [DATABIT-1:0] dp_htb_q, dp_htb_d;
    logic [DATABIT-1:0] dp_ht1_q, dp_ht1_d;
    logic [DATABIT-1:0] dp_zt_q, dp_zt_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               rd_en_c;
    logic               wr_en_c;
    logic               push;
    logic               ovf_hit;

    // Issue/write strobes and FIFO status; everything else keys off these.
    always_comb begin
        fifo_full  = (fifo_cnt_q == DEPTH_C);
        fifo_empty = (fifo_cnt_q == '0);
        wr_en_c    = !fifo_empty && wr_ready;
        // Credit below depth means a FIFO slot is reserved for this element.
        rd_en_c    = (state_q == S_ISSUE) && (credit_q < DEPTH_C) && (issue_cnt_q != len_q);
        // A push into a full FIFO is still fine when the head leaves this cycle.
        push       = dp_result_valid && (!fifo_full || wr_en_c);
        ovf_hit    = dp_result_valid && fifo_full && !wr_en_c;
    end

    // Pass FSM plus issue/write counters.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d       = vec_len;
                    issue_cnt_d = '0;
                    wr_cnt_d    = '0;
                    state_d     = (vec_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rd_en_c) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_d == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
                // The last write always trails the last issue, so no exit here.
                if (wr_en_c) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (wr_en_c) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_d == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Credit tracks elements in flight anywhere between read and write-back.
    always_comb begin
        credit_d = credit_q;
        if (rd_en_c && !wr_en_c) begin
            credit_d = credit_q + 1'b1;
        end else if (!rd_en_c && wr_en_c && (credit_q != '0)) begin
            credit_d = credit_q - 1'b1;
        end
    end

    // Result FIFO pointers, occupancy, storage and sticky overflow flag.
    always_comb begin
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        fifo_mem_d    = fifo_mem_q;
        ovf_d         = ovf_q | ovf_hit;
        if (push) begin
            fifo_mem_d[fifo_wr_ptr_q] = dp_result;
            fifo_wr_ptr_d             = fifo_wr_ptr_q + 1'b1;
        end
        if (wr_en_c) begin
            fifo_rd_ptr_d = fifo_rd_ptr_q + 1'b1;
        end
        unique case ({push, wr_en_c})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Operand registers: capture buffer data at the end of each rd_en cycle.
    always_comb begin
        dp_en_d  = rd_en_c;
        dp_xt_d  = rd_en_c ? mem_xt  : dp_xt_q;
        dp_htb_d = rd_en_c ? mem_htb : dp_htb_q;
        dp_ht1_d = rd_en_c ? mem_ht1 : dp_ht1_q;
        dp_zt_d  = rd_en_c ? mem_zt  : dp_zt_q;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            credit_q    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            credit_q    <= credit_d;
        end
    end

    // FIFO registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
            ovf_q         <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            ovf_q         <= ovf_d;
            fifo_mem_q    <= fifo_mem_d;
        end
    end

    // Datapath operand registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dp_en_q  <= 1'b0;
            dp_xt_q  <= '0;
            dp_htb_q <= '0;
            dp_ht1_q <= '0;
            dp_zt_q  <= '0;
        end else begin
            dp_en_q  <= dp_en_d;
            dp_xt_q  <= dp_xt_d;
            dp_htb_q <= dp_htb_d;
            dp_ht1_q <= dp_ht1_d;
            dp_zt_q  <= dp_zt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign ovf_err   = ovf_q;
    assign rd_en     = rd_en_c;
    assign rd_addr   = issue_cnt_q;
    assign dp_en     = dp_en_q;
    assign dp_xt     = dp_xt_q;
    assign dp_htb    = dp_htb_q;
    assign dp_ht1    = dp_ht1_q;
    assign dp_zt     = dp_zt_q;
    assign wr_en     = wr_en_c;
    assign wr_addr   = wr_cnt_q;
    assign wr_data   = fifo_mem_q[fifo_rd_ptr_q];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gru_hidden_seq.sv
// tb_gru_hidden_seq
//   Bench for gru_hidden_seq: operand buffers as arrays, a fixed-latency
//   datapath model, a per-cycle monitor against a pass-level model with an
//   expected write queue, and directed tests with literal expectations.

module tb_gru_hidden_seq;

    localparam int DATABIT    = 16;
    localparam int ADDRBIT    = 8;
    localparam int DP_LAT     = 6;
    localparam int FIFO_DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               start    = 1'b0;
    logic [ADDRBIT-1:0] vec_len  = '0;
    logic               wr_ready = 1'b0;
    logic               busy, done, ovf_err, rd_en, dp_en, wr_en;
    logic [ADDRBIT-1:0] rd_addr, wr_addr;
    logic [DATABIT-1:0] mem_xt, mem_htb, mem_ht1, mem_zt;
    logic [DATABIT-1:0] dp_xt, dp_htb, dp_ht1, dp_zt;
    logic               dp_result_valid;
    logic [DATABIT-1:0] dp_result, wr_data;
    logic [1:0]         dbg_state;

    logic               inj_valid = 1'b0;
    logic [DATABIT-1:0] inj_data  = '0;

    gru_hidden_seq #(
        .DATABIT(DATABIT), .ADDRBIT(ADDRBIT), .DP_LAT(DP_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .busy(busy), .done(done), .ovf_err(ovf_err),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .mem_xt(mem_xt), .mem_htb(mem_htb), .mem_ht1(mem_ht1), .mem_zt(mem_zt),
        .dp_en(dp_en), .dp_xt(dp_xt), .dp_htb(dp_htb), .dp_ht1(dp_ht1), .dp_zt(dp_zt),
        .dp_result_valid(dp_result_valid), .dp_result(dp_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- operand buffers ----------------
    logic [DATABIT-1:0] xt_arr  [256];
    logic [DATABIT-1:0] htb_arr [256];
    logic [DATABIT-1:0] ht1_arr [256];
    logic [DATABIT-1:0] zt_arr  [256];
    assign mem_xt  = xt_arr[rd_addr];
    assign mem_htb = htb_arr[rd_addr];
    assign mem_ht1 = ht1_arr[rd_addr];
    assign mem_zt  = zt_arr[rd_addr];

    // Q2.14 element function: z*(1-z) * x*(h1-hb)
    function automatic logic [DATABIT-1:0] dp_func(input logic signed [DATABIT-1:0] z,
                                                   input logic signed [DATABIT-1:0] x,
                                                   input logic signed [DATABIT-1:0] h1,
                                                   input logic signed [DATABIT-1:0] hb);
        longint one, a, b, r;
        one = 64'sd16384;
        a = (longint'(z) * (one - longint'(z))) >>> 14;
        b = (longint'(x) * (longint'(h1) - longint'(hb))) >>> 14;
        r = (a * b) >>> 14;
        return r[DATABIT-1:0];
    endfunction

    // ---------------- datapath model, DP_LAT cycles ----------------
    logic               dp_v_pipe [DP_LAT];
    logic [DATABIT-1:0] dp_d_pipe [DP_LAT];
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DP_LAT; i++) begin
                dp_v_pipe[i] <= 1'b0;
                dp_d_pipe[i] <= '0;
            end
        end else begin
            dp_v_pipe[0] <= dp_en;
            dp_d_pipe[0] <= dp_func(dp_zt, dp_xt, dp_ht1, dp_htb);
            for (int i = 1; i < DP_LAT; i++) begin
                dp_v_pipe[i] <= dp_v_pipe[i-1];
                dp_d_pipe[i] <= dp_d_pipe[i-1];
            end
        end
    end
    assign dp_result_valid = dp_v_pipe[DP_LAT-1] | inj_valid;
    assign dp_result       = inj_valid ? inj_data : dp_d_pipe[DP_LAT-1];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int tot_rd   = 0;
    int tot_wr   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Pass-level model: expected {addr,data} writes, issue/write counts, FIFO occupancy.
    logic [ADDRBIT+DATABIT-1:0] exp_q[$];
    logic               m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0, m_prev_rd = 1'b0;
    logic [ADDRBIT-1:0] m_prev_addr = '0;
    int                 m_len = 0, m_issued = 0, m_written = 0, m_occ = 0;

    always @(negedge clk) begin
        logic exp_rd, nxt_done, accept;
        logic [ADDRBIT+DATABIT-1:0] e;
        if (rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_ovf", ovf_err, 0);
            check("rst_rd_en", rd_en, 0);
            check("rst_dp_en", dp_en, 0);
            check("rst_wr_en", wr_en, 0);
            check("rst_rd_addr", rd_addr, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_dp_xt", dp_xt, 0);
            exp_q.delete();
            m_busy = 0; m_done = 0; m_ovf = 0; m_prev_rd = 0;
            m_len = 0; m_issued = 0; m_written = 0; m_occ = 0;
        end else begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("ovf_err", ovf_err, m_ovf);
            check("dp_en", dp_en, m_prev_rd);
            if (m_prev_rd) begin
                check("dp_xt", dp_xt, xt_arr[m_prev_addr]);
                check("dp_htb", dp_htb, htb_arr[m_prev_addr]);
                check("dp_ht1", dp_ht1, ht1_arr[m_prev_addr]);
                check("dp_zt", dp_zt, zt_arr[m_prev_addr]);
            end
            exp_rd = m_busy && (m_issued < m_len) && ((m_issued - m_written) < FIFO_DEPTH);
            check("rd_en", rd_en, exp_rd);
            check("wr_en", wr_en, (m_occ != 0) && wr_ready);
            if (rd_en) begin
                check("rd_addr", rd_addr, m_issued);
                m_issued++;
                tot_rd++;
            end
            nxt_done = 1'b0;
            if (wr_en) begin
                tot_wr++;
                if (exp_q.size() == 0) begin
                    check("wr_spurious", wr_en, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e[ADDRBIT+DATABIT-1:DATABIT]);
                    check("wr_data", wr_data, e[DATABIT-1:0]);
                end
                m_written++;
                if (m_busy && m_written == m_len) nxt_done = 1'b1;
            end
            if (done) done_cnt++;
            accept = start && !m_busy;
            if (m_done) m_busy = 1'b0;
            if (accept) begin
                m_busy = 1'b1;
                m_len = int'(vec_len);
                m_issued = 0;
                m_written = 0;
                for (int i = 0; i < int'(vec_len); i++)
                    exp_q.push_back({ADDRBIT'(i), dp_func(zt_arr[i], xt_arr[i], ht1_arr[i], htb_arr[i])});
                if (vec_len == '0) nxt_done = 1'b1;
            end
            m_done = nxt_done;
            if (dp_result_valid && m_occ == FIFO_DEPTH && !wr_en) m_ovf = 1'b1;
            else m_occ = m_occ + (dp_result_valid ? 1 : 0) - (wr_en ? 1 : 0);
            m_prev_rd = rd_en;
            m_prev_addr = rd_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counts();
        tot_rd = 0; tot_wr = 0; done_cnt = 0;
    endtask

    task automatic fill_ops();
        for (int i = 0; i < 256; i++) begin
            xt_arr[i]  = DATABIT'(16'h0800 + i * 16'h0100);
            htb_arr[i] = DATABIT'(16'h0400 * (i % 4));
            ht1_arr[i] = DATABIT'(16'h2000 - i * 16'h0080);
            zt_arr[i]  = DATABIT'(16'h1000 + (i % 8) * 16'h0200);
        end
    endtask

    task automatic do_start(input int len);
        @(posedge clk); #1;
        start = 1'b1;
        vec_len = ADDRBIT'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check(name, seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k;
        bit seen;
        fill_ops();
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;

        // T1: 4 elements, wr_ready high, first-write latency and done timing
        clear_counts();
        wr_ready = 1'b1;
        do_start(4);
        seen = 1'b0;
        for (k = 1; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (wr_en) seen = 1'b1;
        end
        // accept edge opens cycle 1; wr_en is 2+DP_LAT edges after it
        check("t1_first_wr_cycle", k - 1, DP_LAT + 3);
        wait_done("t1_done_seen", 40);
        check("t1_busy_after_done", busy, 0);
        repeat (4) @(posedge clk); #1;
        check("t1_rd_cnt", tot_rd, 4);
        check("t1_wr_cnt", tot_wr, 4);
        check("t1_done_cnt", done_cnt, 1);

        // T2: 20 elements with sink stalled for 30 cycles
        clear_counts();
        wr_ready = 1'b0;
        do_start(20);
        repeat (30) @(posedge clk); #1;
        check("t2_rd_stall", tot_rd, FIFO_DEPTH);
        check("t2_wr_stall", tot_wr, 0);
        wr_ready = 1'b1;
        wait_done("t2_done_seen", 200);
        check("t2_wr_cnt", tot_wr, 20);
        check("t2_ovf", ovf_err, 0);

        // T3: zero-length pass
        clear_counts();
        do_start(0);
        check("t3_done", done, 1);
        check("t3_busy", busy, 1);
        @(posedge clk); #1;
        check("t3_done_low", done, 0);
        check("t3_busy_low", busy, 0);
        check("t3_no_rw", tot_rd + tot_wr, 0);

        // T4: second start mid-pass ignored
        clear_counts();
        do_start(5);
        repeat (3) @(posedge clk); #1;
        start = 1'b1;
        vec_len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t4_done_seen", 100);
        repeat (4) @(posedge clk); #1;
        check("t4_wr_cnt", tot_wr, 5);
        check("t4_rd_cnt", tot_rd, 5);
        check("t4_done_cnt", done_cnt, 1);

        // T5: reset after 3 writes, then a clean 3-element pass
        clear_counts();
        do_start(6);
        for (k = 0; k < 60 && tot_wr < 3; k++) @(posedge clk);
        check("t5_three_writes", tot_wr, 3);
        #1 rst_n = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_wr_en", wr_en, 0);
        check("t5_rd_en", rd_en, 0);
        check("t5_dp_en", dp_en, 0);
        check("t5_wr_addr", wr_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        clear_counts();
        do_start(3);
        wait_done("t5_done_seen", 60);
        repeat (3) @(posedge clk); #1;
        check("t5_wr_cnt", tot_wr, 3);
        check("t5_done_cnt", done_cnt, 1);

        // T6: bit-exact pass-through and sticky overflow
        check("pin_quarter", dp_func(16'h2000, 16'h4000, 16'h4000, 16'h0000), 16'h1000);
        check("pin_neg_quarter", dp_func(16'h2000, 16'h4000, 16'h0000, 16'h4000), 16'hF000);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            zt_arr[i] = 16'h2000; xt_arr[i] = 16'h4000; ht1_arr[i] = 16'h4000; htb_arr[i] = 16'h0000;
        end
        clear_counts();
        wr_ready = 1'b0;
        do_start(FIFO_DEPTH);
        repeat (20) @(posedge clk); #1;
        check("t6_ovf_before", ovf_err, 0);
        inj_valid = 1'b1;
        inj_data = 16'hDEAD;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        check("t6_ovf_set", ovf_err, 1);
        wr_ready = 1'b1;
        seen = 1'b0;
        for (k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (wr_en) begin
                seen = 1'b1;
                check("t6_first_data", wr_data, 16'h1000);
                check("t6_first_addr", wr_addr, 0);
            end
        end
        check("t6_first_wr_seen", seen, 1);
        wait_done("t6_done_seen", 60);
        repeat (3) @(posedge clk); #1;
        check("t6_wr_cnt", tot_wr, FIFO_DEPTH);
        check("t6_ovf_sticky", ovf_err, 1);
        pulse_reset();
        #1;
        check("t6_ovf_cleared", ovf_err, 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
